// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (port 0) and load/store (port 1).
// One transaction in flight; a missing memory ack is turned into an error response after TIMEOUT_CYCLES.
module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  output logic [31:0] p0_rdata_o,
  output logic        p0_ack_o,
  output logic        p0_err_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  output logic [31:0] p1_rdata_o,
  output logic        p1_ack_o,
  output logic        p1_err_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic        r_winner, w_winner_nxt;
  logic        r_last_grant, w_last_grant_nxt;
  logic        r_we, w_we_nxt;
  logic [7:0]  r_timer, w_timer_nxt;
  logic        r_rd_en, w_rd_en_nxt;
  logic        r_wr_en, w_wr_en_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic        r_ack0, w_ack0_nxt;
  logic        r_ack1, w_ack1_nxt;
  logic        r_err0, w_err0_nxt;
  logic        r_err1, w_err1_nxt;
  logic [31:0] r_rdata0, w_rdata0_nxt;
  logic [31:0] r_rdata1, w_rdata1_nxt;
  logic        w_grant1;
  logic        w_resp_err;
  logic [31:0] w_resp_rdata;

  // On a tie the port that did not win last time gets the memory.
  assign w_grant1 = p1_req_i & (~p0_req_i | ~r_last_grant);

  always_comb begin
    w_state_nxt      = r_state;
    w_winner_nxt     = r_winner;
    w_last_grant_nxt = r_last_grant;
    w_we_nxt         = r_we;
    w_timer_nxt      = r_timer;
    w_rd_en_nxt      = 1'b0;
    w_wr_en_nxt      = 1'b0;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_ack0_nxt       = 1'b0;
    w_ack1_nxt       = 1'b0;
    w_err0_nxt       = 1'b0;
    w_err1_nxt       = 1'b0;
    w_rdata0_nxt     = '0;
    w_rdata1_nxt     = '0;
    w_resp_err       = 1'b0;
    w_resp_rdata     = '0;

    case (r_state)
      S_IDLE: begin
        if (p0_req_i || p1_req_i) begin
          w_winner_nxt     = w_grant1;
          w_last_grant_nxt = w_grant1;
          w_we_nxt         = w_grant1 ? p1_we_i    : p0_we_i;
          w_addr_nxt       = w_grant1 ? p1_addr_i  : p0_addr_i;
          w_wdata_nxt      = w_grant1 ? p1_wdata_i : p0_wdata_i;
          w_rd_en_nxt      = ~w_we_nxt;
          w_wr_en_nxt      = w_we_nxt;
          w_state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack_i || (r_timer == TMO_LAST)) begin
          w_resp_err   = ~mem_ack_i;
          w_resp_rdata = (mem_ack_i && !r_we) ? mem_data_i : '0;
          w_ack0_nxt   = ~r_winner;
          w_ack1_nxt   = r_winner;
          w_err0_nxt   = ~r_winner & w_resp_err;
          w_err1_nxt   = r_winner & w_resp_err;
          w_rdata0_nxt = r_winner ? '0 : w_resp_rdata;
          w_rdata1_nxt = r_winner ? w_resp_rdata : '0;
          w_state_nxt  = S_RESP;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_winner     <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_timer      <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_winner     <= w_winner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_we         <= w_we_nxt;
      r_timer      <= w_timer_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_err0       <= w_err0_nxt;
      r_err1       <= w_err1_nxt;
      r_rdata0     <= w_rdata0_nxt;
      r_rdata1     <= w_rdata1_nxt;
    end
  end

  assign mem_rd_en_o = r_rd_en;
  assign mem_wr_en_o = r_wr_en;
  assign mem_addr_o  = r_addr;
  assign mem_data_o  = r_wdata;
  assign p0_ack_o    = r_ack0;
  assign p1_ack_o    = r_ack1;
  assign p0_err_o    = r_err0;
  assign p1_err_o    = r_err1;
  assign p0_rdata_o  = r_rdata0;
  assign p1_rdata_o  = r_rdata1;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter: memory stub with 2-cycle ack plus a transaction-level reference
// model (round-robin choice, shadow memory, fixed response latency) checked every cycle.
module tb_memory_arbiter;

  localparam int TMO = 15;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req_i = 1'b0, p0_we_i = 1'b0, p1_req_i = 1'b0, p1_we_i = 1'b0;
  logic [31:0] p0_addr_i = '0, p0_wdata_i = '0, p1_addr_i = '0, p1_wdata_i = '0;
  logic [31:0] p0_rdata_o, p1_rdata_o, mem_addr_o, mem_data_o;
  logic        p0_ack_o, p0_err_o, p1_ack_o, p1_err_o, mem_rd_en_o, mem_wr_en_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_ack_i = 1'b0;

  memory_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p0_rdata_o(p0_rdata_o), .p0_ack_o(p0_ack_o), .p0_err_o(p0_err_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p1_rdata_o(p1_rdata_o), .p1_ack_o(p1_ack_o), .p1_err_o(p1_err_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h5A00_0000 ^ (32'(i) * 32'h0001_0203));
  endfunction

  // Memory stub: ack and read data appear two edges after the enable; it keeps running through reset.
  logic [31:0] mem_arr [0:255];
  bit          seeded = 1'b0;
  bit          noack = 1'b0;
  logic        en_d1 = 1'b0;
  logic [31:0] rd_d1 = '0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
      seeded <= 1'b1;
    end else if (mem_wr_en_o) begin
      mem_arr[mem_addr_o[9:2]] <= mem_data_o;
    end
    en_d1      <= mem_rd_en_o | mem_wr_en_o;
    rd_d1      <= mem_rd_en_o ? mem_arr[mem_addr_o[9:2]] : 32'hBAD0_0000;
    mem_ack_i  <= en_d1 & ~noack;
    mem_data_i <= en_d1 ? rd_d1 : 32'hA5A5_A5A5;
  end

  int          total = 0, bad = 0, cyc = 0, grants = 0;
  logic [31:0] ref_mem [0:255];
  txn_t        q0[$], q1[$];
  txn_t        cur[2];
  bit          act[2];
  int          sent[2], done[2];
  bit          mdl_last, infl, infl_port, exp_err, rnd_noack, prev_en, prev_a0, prev_a1;
  logic [31:0] exp_rd;
  int          grant_cyc, exp_lat;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply_inputs();
    p0_req_i = act[0]; p0_we_i = cur[0].we; p0_addr_i = cur[0].addr; p0_wdata_i = cur[0].wdata;
    p1_req_i = act[1]; p1_we_i = cur[1].we; p1_addr_i = cur[1].addr; p1_wdata_i = cur[1].wdata;
  endtask

  task automatic push(int p, bit we, logic [31:0] a, logic [31:0] d, int gap);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.gap = gap;
    if (p == 0) q0.push_back(t); else q1.push_back(t);
    sent[p]++;
  endtask

  task automatic step();
    bit en, p;
    @(negedge clk);
    cyc++;
    en = mem_rd_en_o | mem_wr_en_o;
    chk("en_exclusive", 32'(mem_rd_en_o & mem_wr_en_o), 0);
    chk("en_single_cycle", 32'(en & prev_en), 0);
    chk("ack_exclusive", 32'(p0_ack_o & p1_ack_o), 0);
    chk("ack_single_cycle", 32'((p0_ack_o & prev_a0) | (p1_ack_o & prev_a1)), 0);
    if (!p0_ack_o) chk("p0_quiet", {p0_rdata_o[31:1], p0_rdata_o[0] | p0_err_o}, 0);
    if (!p1_ack_o) chk("p1_quiet", {p1_rdata_o[31:1], p1_rdata_o[0] | p1_err_o}, 0);

    if (en && !prev_en) begin
      grants++;
      chk("grant_while_busy", 32'(infl), 0);
      chk("grant_has_req", 32'(act[0] | act[1]), 1);
      p = (act[0] && act[1]) ? !mdl_last : act[1];
      chk("grant_we", 32'(mem_wr_en_o), 32'(cur[p].we));
      chk("grant_addr", mem_addr_o, cur[p].addr);
      if (cur[p].we) chk("grant_wdata", mem_data_o, cur[p].wdata);
      if (rnd_noack) noack = ($urandom_range(0, 11) == 0);
      mdl_last = p; infl = 1'b1; infl_port = p; grant_cyc = cyc;
      exp_err = noack;
      exp_lat = noack ? TMO + 1 : 3;
      exp_rd  = (noack || cur[p].we) ? 32'h0 : ref_mem[cur[p].addr[9:2]];
      if (cur[p].we) ref_mem[cur[p].addr[9:2]] = cur[p].wdata;
    end

    if (p0_ack_o || p1_ack_o) begin
      p = p1_ack_o;
      chk("ack_expected", 32'(infl), 1);
      if (infl) begin
        chk("ack_port", 32'(p), 32'(infl_port));
        chk("ack_rdata", p ? p1_rdata_o : p0_rdata_o, exp_rd);
        chk("ack_err", 32'(p ? p1_err_o : p0_err_o), 32'(exp_err));
        chk("ack_latency", 32'(cyc - grant_cyc), 32'(exp_lat));
        infl = 1'b0;
        done[p]++;
        act[p] = 1'b0;
      end
    end else if (infl && (cyc - grant_cyc > 40)) begin
      chk("ack_budget", 32'(cyc - grant_cyc), 32'(exp_lat));
      infl = 1'b0;
      act[infl_port] = 1'b0;
    end

    prev_en = en; prev_a0 = p0_ack_o; prev_a1 = p1_ack_o;

    if (!act[0] && q0.size() > 0) begin
      if (q0[0].gap > 0) q0[0].gap--;
      else begin cur[0] = q0.pop_front(); act[0] = 1'b1; end
    end
    if (!act[1] && q1.size() > 0) begin
      if (q1[0].gap > 0) q1[0].gap--;
      else begin cur[1] = q1.pop_front(); act[1] = 1'b1; end
    end
    apply_inputs();
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() > 0 || act[0] || act[1] || infl) && n < 4000) begin
      step();
      n++;
    end
    chk("drain_pending", 32'(q0.size() + q1.size() + int'(act[0]) + int'(act[1])), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_en", {30'd0, mem_rd_en_o, mem_wr_en_o}, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_acks", {28'd0, p0_ack_o, p0_err_o, p1_ack_o, p1_err_o}, 0);
    chk("rst_p0_rdata", p0_rdata_o, 0);
    chk("rst_p1_rdata", p1_rdata_o, 0);
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete();
    act[0] = 1'b0; act[1] = 1'b0;
    infl = 1'b0; mdl_last = 1'b1;
    prev_en = 1'b0; prev_a0 = 1'b0; prev_a1 = 1'b0;
    apply_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int g;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    cur[0] = '{0, 0, 0, 0}; cur[1] = '{0, 0, 0, 0};
    sent[0] = 0; sent[1] = 0; done[0] = 0; done[1] = 0;
    rnd_noack = 1'b0;
    do_reset();

    // single fetch of a preloaded word
    push(0, 0, 32'h10, 0, 0);
    drain();

    // write from load/store port, then fetch of the same word
    push(1, 1, 32'h20, 32'h1234_5678, 0);
    push(0, 0, 32'h20, 0, 3);
    drain();

    // simultaneous requests from reset must alternate starting with port 0
    do_reset();
    push(0, 0, 32'h40, 0, 0); push(0, 0, 32'h44, 0, 0);
    push(1, 0, 32'h80, 0, 0); push(1, 0, 32'h84, 0, 0);
    drain();

    // memory never acks: error response, then normal service resumes
    noack = 1'b1;
    push(1, 0, 32'h24, 0, 0);
    drain();
    noack = 1'b0;
    push(0, 0, 32'h24, 0, 0);
    drain();

    // randomized traffic with occasional missing acks
    rnd_noack = 1'b1;
    for (int i = 0; i < 120; i++)
      push(int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           32'($urandom_range(0, 63)) << 2, $urandom, int'($urandom_range(0, 3)));
    drain();
    rnd_noack = 1'b0;
    noack = 1'b0;
    chk("p0_done", 32'(done[0]), 32'(sent[0]));
    chk("p1_done", 32'(done[1]), 32'(sent[1]));

    // reset while a fetch waits for memory; the late memory ack must not reach the requester
    push(0, 0, 32'h30, 0, 0);
    g = grants;
    for (int n = 0; n < 10 && grants == g; n++) step();
    chk("rst_test_granted", 32'(grants - g), 1);
    step();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    clear_model();
    #1 rst_n = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
